// File: rtl/exp_sum_buffer.sv
// Frame buffer and full-precision accumulator between the exp2 stage and the divider.
// It collects number_of_data exp values, then presents their sum and replays the values one per handshake.
//
// state   | meaning
// COLLECT | storing inputs into the buffer and accumulating the sum
// DRAIN   | sum presented, replaying buffered values to the divider
module exp_sum_buffer #(
  parameter int data_size      = 32,
  parameter int number_of_data = 10,
  parameter int sum_size       = 36,
  parameter int index_size     = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic [data_size-1:0]  exp_sum_data_i,
  input  logic                  exp_sum_data_valid_i,
  input  logic                  exp_sum_ready_i,
  output logic [sum_size-1:0]   exp_sum_o,
  output logic                  exp_sum_valid_o,
  output logic [data_size-1:0]  exp_sum_data_o,
  output logic                  exp_sum_data_valid_o,
  output logic [index_size-1:0] exp_sum_index_o,
  output logic                  exp_sum_last_o,
  output logic                  exp_sum_drop_o,
  output logic                  exp_sum_busy_o
);

  localparam int addr_size = (number_of_data > 1) ? $clog2(number_of_data) : 1;
  localparam logic [index_size-1:0] last_idx = index_size'(number_of_data - 1);

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t                state;
  logic [index_size-1:0] wr_cnt;
  logic [index_size-1:0] rd_cnt;
  logic [index_size-1:0] rd_next;
  logic [sum_size-1:0]   acc;
  logic [sum_size-1:0]   data_ext;
  logic [data_size-1:0]  buf_mem [number_of_data];

  assign data_ext = sum_size'(exp_sum_data_i);
  assign rd_next  = rd_cnt + 1'b1;

  // Buffer contents carry no reset; they are always written before being read.
  always_ff @(posedge clock_i) begin
    if (state == COLLECT && exp_sum_data_valid_i)
      buf_mem[wr_cnt[addr_size-1:0]] <= exp_sum_data_i;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state                <= COLLECT;
      wr_cnt               <= '0;
      rd_cnt               <= '0;
      acc                  <= '0;
      exp_sum_o            <= '0;
      exp_sum_valid_o      <= 1'b0;
      exp_sum_data_o       <= '0;
      exp_sum_data_valid_o <= 1'b0;
      exp_sum_index_o      <= '0;
      exp_sum_last_o       <= 1'b0;
      exp_sum_drop_o       <= 1'b0;
      exp_sum_busy_o       <= 1'b0;
    end else begin
      exp_sum_valid_o <= 1'b0;
      exp_sum_drop_o  <= 1'b0;
      case (state)
        COLLECT: begin
          if (exp_sum_data_valid_i) begin
            if (wr_cnt == last_idx) begin
              // buf_mem[0] was written on an earlier cycle since a frame has at least two values
              exp_sum_o            <= acc + data_ext;
              exp_sum_valid_o      <= 1'b1;
              acc                  <= '0;
              wr_cnt               <= '0;
              rd_cnt               <= '0;
              state                <= DRAIN;
              exp_sum_data_o       <= buf_mem[0];
              exp_sum_data_valid_o <= 1'b1;
              exp_sum_index_o      <= '0;
              exp_sum_last_o       <= 1'b0;
              exp_sum_busy_o       <= 1'b1;
            end else begin
              acc    <= acc + data_ext;
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          exp_sum_drop_o <= exp_sum_data_valid_i;
          if (exp_sum_ready_i) begin
            if (rd_cnt == last_idx) begin
              rd_cnt               <= '0;
              state                <= COLLECT;
              exp_sum_data_o       <= '0;
              exp_sum_data_valid_o <= 1'b0;
              exp_sum_index_o      <= '0;
              exp_sum_last_o       <= 1'b0;
              exp_sum_busy_o       <= 1'b0;
            end else begin
              rd_cnt          <= rd_next;
              exp_sum_data_o  <= buf_mem[rd_next[addr_size-1:0]];
              exp_sum_index_o <= rd_next;
              exp_sum_last_o  <= (rd_next == last_idx);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_sum_buffer.sv
// Directed bench for exp_sum_buffer with a four-value frame.
// Each scenario task drives its stimulus and compares outputs against hand-computed values.
module tb_exp_sum_buffer;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int SW = 36;
  localparam int IW = 4;

  logic          clock_i = 1'b0;
  logic          reset_n_i;
  logic [DW-1:0] exp_sum_data_i;
  logic          exp_sum_data_valid_i;
  logic          exp_sum_ready_i;
  logic [SW-1:0] exp_sum_o;
  logic          exp_sum_valid_o;
  logic [DW-1:0] exp_sum_data_o;
  logic          exp_sum_data_valid_o;
  logic [IW-1:0] exp_sum_index_o;
  logic          exp_sum_last_o;
  logic          exp_sum_drop_o;
  logic          exp_sum_busy_o;

  int vectors     = 0;
  int miscompares = 0;

  exp_sum_buffer #(
    .data_size(DW), .number_of_data(N), .sum_size(SW), .index_size(IW)
  ) dut (
    .clock_i              (clock_i),
    .reset_n_i            (reset_n_i),
    .exp_sum_data_i       (exp_sum_data_i),
    .exp_sum_data_valid_i (exp_sum_data_valid_i),
    .exp_sum_ready_i      (exp_sum_ready_i),
    .exp_sum_o            (exp_sum_o),
    .exp_sum_valid_o      (exp_sum_valid_o),
    .exp_sum_data_o       (exp_sum_data_o),
    .exp_sum_data_valid_o (exp_sum_data_valid_o),
    .exp_sum_index_o      (exp_sum_index_o),
    .exp_sum_last_o       (exp_sum_last_o),
    .exp_sum_drop_o       (exp_sum_drop_o),
    .exp_sum_busy_o       (exp_sum_busy_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    vectors += 8;
    if (exp_sum_o !== '0) begin miscompares++; $display("FAIL %s sum: got %h expected 0", tag, exp_sum_o); end
    if (exp_sum_valid_o !== 1'b0) begin miscompares++; $display("FAIL %s sum_valid: got %b expected 0", tag, exp_sum_valid_o); end
    if (exp_sum_data_o !== '0) begin miscompares++; $display("FAIL %s data: got %h expected 0", tag, exp_sum_data_o); end
    if (exp_sum_data_valid_o !== 1'b0) begin miscompares++; $display("FAIL %s data_valid: got %b expected 0", tag, exp_sum_data_valid_o); end
    if (exp_sum_index_o !== '0) begin miscompares++; $display("FAIL %s index: got %0d expected 0", tag, exp_sum_index_o); end
    if (exp_sum_last_o !== 1'b0) begin miscompares++; $display("FAIL %s last: got %b expected 0", tag, exp_sum_last_o); end
    if (exp_sum_drop_o !== 1'b0) begin miscompares++; $display("FAIL %s drop: got %b expected 0", tag, exp_sum_drop_o); end
    if (exp_sum_busy_o !== 1'b0) begin miscompares++; $display("FAIL %s busy: got %b expected 0", tag, exp_sum_busy_o); end
  endtask

  task automatic send_frame(input logic [DW-1:0] vals [N], input int gap);
    for (int i = 0; i < N; i++) begin
      exp_sum_data_i = vals[i];
      exp_sum_data_valid_i = 1'b1;
      step();
      exp_sum_data_valid_i = 1'b0;
      exp_sum_data_i = '0;
      if (i < N - 1) begin
        vectors += 2;
        if (exp_sum_valid_o !== 1'b0) begin miscompares++; $display("FAIL early_sum_valid elem %0d: got %b expected 0", i, exp_sum_valid_o); end
        if (exp_sum_busy_o !== 1'b0) begin miscompares++; $display("FAIL early_busy elem %0d: got %b expected 0", i, exp_sum_busy_o); end
        repeat (gap) step();
      end
    end
  endtask

  task automatic check_sum(input string tag, input logic [SW-1:0] exp_sum);
    vectors += 4;
    if (exp_sum_o !== exp_sum) begin miscompares++; $display("FAIL %s sum: got %h expected %h", tag, exp_sum_o, exp_sum); end
    if (exp_sum_valid_o !== 1'b1) begin miscompares++; $display("FAIL %s sum_valid: got %b expected 1", tag, exp_sum_valid_o); end
    if (exp_sum_data_valid_o !== 1'b1) begin miscompares++; $display("FAIL %s first_data_valid: got %b expected 1", tag, exp_sum_data_valid_o); end
    if (exp_sum_busy_o !== 1'b1) begin miscompares++; $display("FAIL %s busy: got %b expected 1", tag, exp_sum_busy_o); end
  endtask

  // Replays the frame under a ready pattern (bit k used on cycle k) and checks order, holds and the exit.
  task automatic drain(input string tag, input logic [DW-1:0] vals [N], input logic [15:0] pat,
                       input int len, input logic [SW-1:0] exp_sum);
    int hs = 0;
    for (int k = 0; k < len; k++) begin
      exp_sum_ready_i = pat[k];
      if (hs < N) begin
        vectors += 4;
        if (exp_sum_data_valid_o !== 1'b1) begin miscompares++; $display("FAIL %s data_valid cyc %0d: got %b expected 1", tag, k, exp_sum_data_valid_o); end
        if (exp_sum_data_o !== vals[hs]) begin miscompares++; $display("FAIL %s data cyc %0d: got %h expected %h", tag, k, exp_sum_data_o, vals[hs]); end
        if (exp_sum_index_o !== IW'(hs)) begin miscompares++; $display("FAIL %s index cyc %0d: got %0d expected %0d", tag, k, exp_sum_index_o, hs); end
        if (exp_sum_last_o !== (hs == N - 1)) begin miscompares++; $display("FAIL %s last cyc %0d: got %b expected %b", tag, k, exp_sum_last_o, hs == N - 1); end
      end
      step();
      if (pat[k]) hs++;
      vectors++;
      if (exp_sum_valid_o !== 1'b0) begin miscompares++; $display("FAIL %s sum_valid_pulse cyc %0d: got %b expected 0", tag, k, exp_sum_valid_o); end
    end
    exp_sum_ready_i = 1'b0;
    vectors += 5;
    if (hs !== N) begin miscompares++; $display("FAIL %s handshakes: got %0d expected %0d", tag, hs, N); end
    if (exp_sum_data_valid_o !== 1'b0) begin miscompares++; $display("FAIL %s end_data_valid: got %b expected 0", tag, exp_sum_data_valid_o); end
    if (exp_sum_busy_o !== 1'b0) begin miscompares++; $display("FAIL %s end_busy: got %b expected 0", tag, exp_sum_busy_o); end
    if (exp_sum_last_o !== 1'b0) begin miscompares++; $display("FAIL %s end_last: got %b expected 0", tag, exp_sum_last_o); end
    if (exp_sum_o !== exp_sum) begin miscompares++; $display("FAIL %s held_sum: got %h expected %h", tag, exp_sum_o, exp_sum); end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    exp_sum_data_i = '0;
    exp_sum_data_valid_i = 1'b0;
    exp_sum_ready_i = 1'b0;
    repeat (2) step();
    check_all_zero("reset");
    reset_n_i = 1'b1;
    step();
    check_all_zero("post_reset");
  endtask

  task automatic test_basic();
    logic [DW-1:0] v [N];
    v = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    exp_sum_ready_i = 1'b1;
    send_frame(v, 0);
    check_sum("basic", 36'h100000000);
    drain("basic", v, 16'h000F, 4, 36'h100000000);
  endtask

  task automatic test_max_values();
    logic [DW-1:0] v [N];
    v = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    send_frame(v, 0);
    check_sum("max", 36'h3FFFFFFFC);
    drain("max", v, 16'h000F, 4, 36'h3FFFFFFFC);
  endtask

  task automatic test_ready_toggle();
    logic [DW-1:0] v [N];
    v = '{32'h10000000, 32'h20000000, 32'h30000000, 32'h40000000};
    exp_sum_ready_i = 1'b1;
    send_frame(v, 2);
    check_sum("toggle", 36'h0A0000000);
    // ready sequence 1,0,0,1,1,0,1
    drain("toggle", v, 16'h0059, 7, 36'h0A0000000);
  endtask

  task automatic test_drop();
    logic [DW-1:0] v [N];
    logic [DW-1:0] w [N];
    int drops = 0;
    v = '{32'h01000000, 32'h01000000, 32'h01000000, 32'h01000000};
    w = '{32'h08000000, 32'h08000000, 32'h08000000, 32'h08000000};
    send_frame(v, 0);
    check_sum("drop_frame", 36'h004000000);
    exp_sum_ready_i = 1'b1;
    for (int k = 0; k < N; k++) begin
      exp_sum_data_valid_i = (k == 1 || k == 3);
      exp_sum_data_i = 32'h7FFFFFFF;
      vectors++;
      if (exp_sum_data_o !== v[k]) begin miscompares++; $display("FAIL drop data cyc %0d: got %h expected %h", k, exp_sum_data_o, v[k]); end
      step();
      if (exp_sum_drop_o === 1'b1) drops++;
      vectors++;
      if (exp_sum_drop_o !== (k == 1 || k == 3)) begin miscompares++; $display("FAIL drop pulse cyc %0d: got %b expected %b", k, exp_sum_drop_o, k == 1 || k == 3); end
    end
    exp_sum_data_valid_i = 1'b0;
    exp_sum_data_i = '0;
    vectors += 3;
    if (drops !== 2) begin miscompares++; $display("FAIL drop count: got %0d expected 2", drops); end
    if (exp_sum_busy_o !== 1'b0) begin miscompares++; $display("FAIL drop end_busy: got %b expected 0", exp_sum_busy_o); end
    if (exp_sum_o !== 36'h004000000) begin miscompares++; $display("FAIL drop held_sum: got %h expected %h", exp_sum_o, 36'h004000000); end
    send_frame(w, 0);
    check_sum("after_drop", 36'h020000000);
    drain("after_drop", w, 16'h000F, 4, 36'h020000000);
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] v [N];
    logic [DW-1:0] p [N];
    v = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    p = '{32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111};
    exp_sum_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_sum_data_i = 32'h55555555;
      exp_sum_data_valid_i = 1'b1;
      step();
    end
    exp_sum_data_valid_i = 1'b0;
    reset_n_i = 1'b0;
    #1;
    check_all_zero("rst_collect");
    step();
    reset_n_i = 1'b1;
    step();
    check_all_zero("rst_collect_idle");
    send_frame(v, 0);
    check_sum("rst_collect_fresh", 36'h100000000);
    drain("rst_collect_fresh", v, 16'h000F, 4, 36'h100000000);

    exp_sum_ready_i = 1'b0;
    send_frame(p, 0);
    check_sum("rst_drain_frame", 36'h044444444);
    exp_sum_ready_i = 1'b1;
    step();
    exp_sum_ready_i = 1'b0;
    vectors++;
    if (exp_sum_index_o !== IW'(1)) begin miscompares++; $display("FAIL rst_drain index: got %0d expected 1", exp_sum_index_o); end
    reset_n_i = 1'b0;
    #1;
    check_all_zero("rst_drain");
    step();
    reset_n_i = 1'b1;
    exp_sum_ready_i = 1'b1;
    repeat (2) step();
    check_all_zero("rst_drain_idle");
    send_frame(v, 0);
    check_sum("rst_drain_fresh", 36'h100000000);
    drain("rst_drain_fresh", v, 16'h000F, 4, 36'h100000000);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_values();
    test_ready_toggle();
    test_drop();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
